// File: rtl/mem_access_aligner.sv
// rtl/mem_access_aligner.sv - load/store alignment unit between MEM stage and data cache port
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses respond with an error instead of splitting)
module mem_access_aligner #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              dc_valid,
  input  logic              dc_ready,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [XLEN/8-1:0] dc_we_mask,
  output logic [XLEN-1:0]   dc_wdata,
  input  logic              dc_rvalid,
  input  logic [XLEN-1:0]   dc_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam logic [OW:0] NB_W = (OW+1)'(NB);

  typedef logic [2*NB-1:0]   mask2_t;
  typedef logic [2*XLEN-1:0] data2_t;

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

  state_t            state, state_n;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              resp_err_q;

  logic [OW-1:0]     off;
  logic              split;
  logic [ADDR_W-1:0] a0, a1;
  mask2_t            mask_wide;
  data2_t            data_wide;
  logic [XLEN-1:0]   rd_lo, rd_hi;
  logic [OW+3:0]     sh_hi;

  logic              accept;
  logic              lo_set;
  logic              resp_set;
  logic [XLEN-1:0]   resp_rdata_d;
  logic              resp_err_d;

  function automatic logic crosses(input logic [OW-1:0] o, input logic [1:0] sz);
    logic [4:0] span;
    span = 5'(o) + (5'd1 << sz);
    return span > 5'(NB);
  endfunction

  function automatic logic size_illegal(input logic [1:0] sz);
    return (XLEN == 32) && (sz == 2'b11);
  endfunction

  // Left-justify the access so bit 8S-1 lands on the MSB, then shift back.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] sz,
                                             input logic uns);
    logic [7:0]             sh;
    logic [XLEN-1:0]        t;
    logic signed [XLEN-1:0] ts;
    sh = 8'(XLEN) - (8'd8 << sz);
    t  = v << sh;
    ts = $signed(t) >>> sh;
    return uns ? (t >> sh) : $unsigned(ts);
  endfunction

  always_comb begin
    off       = r_addr[OW-1:0];
    split     = crosses(off, r_funct3[1:0]);
    a0        = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
    a1        = a0 + ADDR_W'(NB);
    // Low half of the wide mask/data serves beat 0, the high half spills into beat 1.
    mask_wide = ((mask2_t'(1) << (4'd1 << r_funct3[1:0])) - mask2_t'(1)) << off;
    data_wide = data2_t'(r_wdata) << {off, 3'b000};
    sh_hi     = {NB_W - {1'b0, off}, 3'b000};
    rd_lo     = dc_rdata >> {off, 3'b000};
    rd_hi     = dc_rdata << sh_hi;
  end

  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    lo_set       = 1'b0;
    resp_set     = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (size_illegal(req_funct3[1:0])) begin
            state_n    = RESP;
            resp_set   = 1'b1;
            resp_err_d = 1'b1;
          end
`ifdef MISALIGN_TRAP_EN
          else if (crosses(req_addr[OW-1:0], req_funct3[1:0])) begin
            state_n    = RESP;
            resp_set   = 1'b1;
            resp_err_d = 1'b1;
          end
`endif
          else begin
            state_n = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (dc_ready) begin
          if (!r_we) begin
            state_n = WAIT0;
          end else if (split) begin
            state_n = BEAT1;
          end else begin
            state_n  = RESP;
            resp_set = 1'b1;
          end
        end
      end
      WAIT0: begin
        if (dc_rvalid) begin
          if (split) begin
            state_n = BEAT1;
            lo_set  = 1'b1;
          end else begin
            state_n      = RESP;
            resp_set     = 1'b1;
            resp_rdata_d = extend(rd_lo, r_funct3[1:0], r_funct3[2]);
          end
        end
      end
      BEAT1: begin
        if (dc_ready) begin
          if (r_we) begin
            state_n  = RESP;
            resp_set = 1'b1;
          end else begin
            state_n = WAIT1;
          end
        end
      end
      WAIT1: begin
        if (dc_rvalid) begin
          state_n      = RESP;
          resp_set     = 1'b1;
          resp_rdata_d = extend(r_lo | rd_hi, r_funct3[1:0], r_funct3[2]);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lo         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (lo_set) begin
        r_lo <= rd_lo;
      end
      if (resp_set) begin
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    dc_valid   = 1'b0;
    dc_addr    = '0;
    dc_we_mask = '0;
    dc_wdata   = '0;
    resp_valid = (state == RESP);
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
    if (state == BEAT0) begin
      dc_valid = 1'b1;
      dc_addr  = a0;
      if (r_we) begin
        dc_we_mask = mask_wide[NB-1:0];
        dc_wdata   = data_wide[XLEN-1:0];
      end
    end else if (state == BEAT1) begin
      dc_valid = 1'b1;
      dc_addr  = a1;
      if (r_we) begin
        dc_we_mask = mask_wide[2*NB-1:NB];
        dc_wdata   = data_wide[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_aligner.sv
// tb/tb_mem_access_aligner.sv - directed vector bench for mem_access_aligner (XLEN=32)
module tb_mem_access_aligner;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              dc_valid;
  logic              dc_ready = 1'b1;
  logic [ADDR_W-1:0] dc_addr;
  logic [3:0]        dc_we_mask;
  logic [XLEN-1:0]   dc_wdata;
  logic              dc_rvalid = 1'b0;
  logic [XLEN-1:0]   dc_rdata = '0;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  int tests  = 0;
  int failed = 0;

  mem_access_aligner #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr),
    .dc_we_mask(dc_we_mask), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rd0, rd1;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] w1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int nbeats,
                              input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                              input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd0 = rd0; v.rd1 = rd1; v.nbeats = nbeats;
    v.a0 = a0; v.m0 = m0; v.w0 = w0; v.a1 = a1; v.m1 = m1; v.w1 = w1;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] ba[2];
    logic [3:0]  bm[2];
    logic [31:0] bw[2];
    int          nb, lat, exp_nb;
    bit          pend, got, hs, sp;
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    sp = (v.f3[1:0] != 2'b11) && ((v.addr % 4) + (1 << v.f3[1:0]) > 4);
    exp_nb = v.nbeats; exp_rd = v.rdata; exp_er = v.err;
    if (TRAP && sp) begin
      exp_nb = 0; exp_rd = 0; exp_er = 1'b1;
    end
    nb = 0; lat = 0; pend = 0; got = 0; rd = 0; er = 0;
    ba[0] = 0; ba[1] = 0; bm[0] = 0; bm[1] = 0; bw[0] = 0; bw[1] = 0;
    dc_ready = 1'b1;
    @(negedge clk);
    chk({v.name, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (k > 1) @(negedge clk);
      hs = 0;
      if (resp_valid) begin
        got = 1; lat = k; rd = resp_rdata; er = resp_err;
      end else if (dc_valid && dc_ready) begin
        if (nb < 2) begin
          ba[nb] = dc_addr; bm[nb] = dc_we_mask; bw[nb] = dc_wdata;
        end
        nb++;
        hs = 1;
      end
      dc_rvalid = pend;
      dc_rdata  = (nb <= 1) ? v.rd0 : v.rd1;
      pend = hs && !v.we;
    end
    dc_rvalid = 1'b0;
    chk({v.name, "_resp_seen"}, 64'(got), 64'd1);
    chk({v.name, "_beats"}, 64'(nb), 64'(exp_nb));
    if (exp_nb >= 1 && nb >= 1) begin
      chk({v.name, "_addr0"}, 64'(ba[0]), 64'(v.a0));
      chk({v.name, "_mask0"}, 64'(bm[0]), 64'(v.m0));
      if (v.we) chk({v.name, "_wdata0"}, 64'(bw[0]), 64'(v.w0));
    end
    if (exp_nb == 2 && nb == 2) begin
      chk({v.name, "_addr1"}, 64'(ba[1]), 64'(v.a1));
      chk({v.name, "_mask1"}, 64'(bm[1]), 64'(v.m1));
      if (v.we) chk({v.name, "_wdata1"}, 64'(bw[1]), 64'(v.w1));
    end
    if (got) begin
      chk({v.name, "_rdata"}, 64'(rd), 64'(exp_rd));
      chk({v.name, "_err"}, 64'(er), 64'(exp_er));
      if (v.we && exp_nb > 0) chk({v.name, "_latency"}, 64'(lat), 64'(exp_nb + 1));
      @(negedge clk);
      chk({v.name, "_resp_pulse"}, 64'(resp_valid), 64'd0);
      chk({v.name, "_rdata_hold"}, 64'(resp_rdata), 64'(exp_rd));
      chk({v.name, "_ready_back"}, 64'(req_ready), 64'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({name, "_dc_valid"}, 64'(dc_valid), 64'd0);
    chk({name, "_dc_addr"}, 64'(dc_addr), 64'd0);
    chk({name, "_dc_mask"}, 64'(dc_we_mask), 64'd0);
    chk({name, "_dc_wdata"}, 64'(dc_wdata), 64'd0);
    chk({name, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({name, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({name, "_resp_err"}, 64'(resp_err), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk("sb_1003",   1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 1,
                  32'h1000, 4'b1000, 32'hAB00_0000, 0, 0, 0, 32'h0, 0);
    vecs[1]  = mk("lh_2002",   0, 3'b001, 32'h2002, 0, 32'h8001_1234, 0, 1,
                  32'h2000, 4'b0000, 0, 0, 0, 0, 32'hFFFF_8001, 0);
    vecs[2]  = mk("lhu_2002",  0, 3'b101, 32'h2002, 0, 32'h8001_1234, 0, 1,
                  32'h2000, 4'b0000, 0, 0, 0, 0, 32'h0000_8001, 0);
    vecs[3]  = mk("sw_3001",   1, 3'b010, 32'h3001, 32'h1122_3344, 0, 0, 2,
                  32'h3000, 4'b1110, 32'h2233_4400, 32'h3004, 4'b0001, 32'h0000_0011, 32'h0, 0);
    vecs[4]  = mk("lw_4003",   0, 3'b010, 32'h4003, 0, 32'hAA00_0000, 32'h00CC_BBDD, 2,
                  32'h4000, 4'b0000, 0, 32'h4004, 4'b0000, 0, 32'hCCBB_DDAA, 0);
    vecs[5]  = mk("illegal",   0, 3'b011, 32'h5000, 0, 32'h1234_5678, 0, 0,
                  0, 0, 0, 0, 0, 0, 32'h0, 1);
    vecs[6]  = mk("sw_wrap",   1, 3'b010, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 0, 0, 2,
                  32'hFFFF_FFFC, 4'b1100, 32'hBEEF_0000, 32'h0000_0000, 4'b0011, 32'h0000_DEAD, 32'h0, 0);
    vecs[7]  = mk("lb_6001",   0, 3'b000, 32'h6001, 0, 32'h0000_F700, 0, 1,
                  32'h6000, 4'b0000, 0, 0, 0, 0, 32'hFFFF_FFF7, 0);
    vecs[8]  = mk("lbu_6001",  0, 3'b100, 32'h6001, 0, 32'h0000_F700, 0, 1,
                  32'h6000, 4'b0000, 0, 0, 0, 0, 32'h0000_00F7, 0);
    vecs[9]  = mk("sh_7001",   1, 3'b001, 32'h7001, 32'h0000_BEEF, 0, 0, 1,
                  32'h7000, 4'b0110, 32'h00BE_EF00, 0, 0, 0, 32'h0, 0);
    vecs[10] = mk("sh_7003",   1, 3'b001, 32'h7003, 32'h0000_1234, 0, 0, 2,
                  32'h7000, 4'b1000, 32'h3400_0000, 32'h7004, 4'b0001, 32'h0000_0012, 32'h0, 0);
    vecs[11] = mk("lh_8003",   0, 3'b001, 32'h8003, 0, 32'h8000_0000, 32'h0000_00FF, 2,
                  32'h8000, 4'b0000, 0, 32'h8004, 4'b0000, 0, 32'hFFFF_FF80, 0);
    vecs[12] = mk("lw_9000",   0, 3'b010, 32'h9000, 0, 32'h1234_5678, 0, 1,
                  32'h9000, 4'b0000, 0, 0, 0, 0, 32'h1234_5678, 0);

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Beat 0 stalled for three cycles with a stray rvalid that must be ignored.
    @(negedge clk);
    dc_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'hA004; req_wdata = 0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_valid0", 64'(dc_valid), 64'd1);
    chk("stall_addr0", 64'(dc_addr), 64'hA004);
    dc_rvalid = 1'b1; dc_rdata = 32'hDEAD_DEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'(dc_valid), 64'd1);
      chk("stall_addr", 64'(dc_addr), 64'hA004);
      chk("stall_mask", 64'(dc_we_mask), 64'd0);
    end
    dc_rvalid = 1'b0; dc_ready = 1'b1;
    @(negedge clk);
    chk("stall_wait_valid", 64'(dc_valid), 64'd0);
    chk("stall_no_early_resp", 64'(resp_valid), 64'd0);
    dc_rvalid = 1'b1; dc_rdata = 32'h1234_5678;
    @(negedge clk);
    dc_rvalid = 1'b0;
    chk("stall_resp_valid", 64'(resp_valid), 64'd1);
    chk("stall_rdata", 64'(resp_rdata), 64'h1234_5678);
    @(negedge clk);

    // Reset dropped while waiting for load data.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = TRAP ? 32'h4000 : 32'h4003;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    dc_rvalid = 1'b1; dc_rdata = 32'hAA00_0000;
    if (!TRAP) begin
      @(negedge clk);
      dc_rvalid = 1'b0;
      chk("rst_beat1_valid", 64'(dc_valid), 64'd1);
      chk("rst_beat1_addr", 64'(dc_addr), 64'h4004);
      @(negedge clk);
      chk("rst_wait1_valid", 64'(dc_valid), 64'd0);
    end else begin
      dc_rvalid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dc_rvalid = 1'b1; dc_rdata = 32'h00CC_BBDD;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("postrst_no_resp", 64'(resp_valid), 64'd0);
      chk("postrst_no_beat", 64'(dc_valid), 64'd0);
    end
    dc_rvalid = 1'b0;
    run_vec(vecs[12]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
